// File: rtl/shifter_pkg.sv
// Shared shifter definitions: normalizer FSM states and the ALU shift-direction encoding.
package shifter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } norm_state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_normalizer_if.sv
// Start/done handshake bundle for shift_normalizer.
// The direction signal exists only when SHIFT_NORM_RIGHT_EN is defined.
interface shift_normalizer_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
);
    logic             start;
    logic [WIDTH-1:0] operand;
`ifdef SHIFT_NORM_RIGHT_EN
    logic             direction;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [CNT_W-1:0] shift_count;
    logic             zero;

`ifdef SHIFT_NORM_RIGHT_EN
    modport master (
        output start, operand, direction,
        input  busy, done, result, shift_count, zero
    );
    modport slave (
        input  start, operand, direction,
        output busy, done, result, shift_count, zero
    );
`else
    modport master (
        output start, operand,
        input  busy, done, result, shift_count, zero
    );
    modport slave (
        input  start, operand,
        output busy, done, result, shift_count, zero
    );
`endif

endinterface

// File: rtl/shift_normalizer.sv
// Iterative normalizer: shifts the operand one bit per cycle until its leading 1 reaches the
// target end and reports the distance. Right (trailing-zero) mode is enabled by SHIFT_NORM_RIGHT_EN.
module shift_normalizer
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    shift_normalizer_if.slave bus
);

    norm_state_t      state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             zero_q, zero_d;
    logic             dir_q, dir_d;
    logic             dir_in;
    logic             target_hit;
    logic             operand_zero;

`ifdef SHIFT_NORM_RIGHT_EN
    assign dir_in = bus.direction;
`else
    assign dir_in = DIR_LEFT;
`endif

    assign operand_zero = (bus.operand == '0);
    assign target_hit   = (dir_q == DIR_RIGHT) ? data_q[0] : data_q[WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = operand_zero ? DONE : SHIFT;
            SHIFT:   if (target_hit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The working register doubles as the result output, so it only moves in SHIFT
    // and on an accepted start; otherwise the last result is held.
    always_comb begin
        data_d  = data_q;
        count_d = count_q;
        zero_d  = zero_q;
        dir_d   = dir_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    data_d  = bus.operand;
                    dir_d   = dir_in;
                    zero_d  = operand_zero;
                    count_d = operand_zero ? CNT_W'(WIDTH) : '0;
                end
            end
            SHIFT: begin
                if (!target_hit) begin
                    data_d  = (dir_q == DIR_RIGHT) ? (data_q >> 1) : (data_q << 1);
                    count_d = count_q + CNT_W'(1);
                end
            end
            default: begin
                data_d = data_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            count_q <= '0;
            zero_q  <= 1'b0;
            dir_q   <= DIR_LEFT;
        end else begin
            data_q  <= data_d;
            count_q <= count_d;
            zero_q  <= zero_d;
            dir_q   <= dir_d;
        end
    end

    always_comb begin
        bus.busy        = (state_q != IDLE);
        bus.done        = (state_q == DONE);
        bus.result      = data_q;
        bus.shift_count = count_q;
        bus.zero        = zero_q;
    end

endmodule

// File: tb/tb_shift_normalizer.sv
// Directed testbench for shift_normalizer; latency is counted in edges with the
// accepting edge as edge 1. Define SHIFT_NORM_RIGHT_EN to also exercise right mode.
module tb_shift_normalizer;

   localparam int WIDTH = 8;
   localparam int CNT_W = $clog2(WIDTH + 1);

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   shift_normalizer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

   shift_normalizer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Free-running 100 MHz clock; all sampling happens 1 time unit after posedge.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every comparison funnels through here so the summary counts stay consistent.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Issues one start, optionally pokes a second start while busy, then waits (bounded)
   // for done and reports the latency in edges from the accepting edge.
   task automatic applyStimulus(input logic [WIDTH-1:0] op, input logic dir,
                                input bit intrude, output int lat);
      @(negedge clk);
      bus.start   = 1'b1;
      bus.operand = op;
`ifdef SHIFT_NORM_RIGHT_EN
      bus.direction = dir;
`endif
      @(posedge clk);
      #1;
      bus.start   = 1'b0;
      bus.operand = '0;
`ifdef SHIFT_NORM_RIGHT_EN
      bus.direction = 1'b0;
`endif
      lat = 1;
      while (!bus.done && lat < 40) begin
         if (intrude && lat == 2) begin
            bus.start   = 1'b1;
            bus.operand = 8'h80;
         end
         @(posedge clk);
         #1;
         bus.start = 1'b0;
         lat++;
      end
      if (!bus.done) checkOutput("done_timeout", {31'd0, bus.done}, 32'd1);
   endtask

   // Checks a finished operation and that done drops back after exactly one cycle.
   task automatic checkResult(input string tag, input int lat, input int expLat,
                              input logic [WIDTH-1:0] expRes, input int expCnt,
                              input logic expZero);
      checkOutput({tag, "_latency"}, lat, expLat);
      checkOutput({tag, "_result"}, {24'd0, bus.result}, {24'd0, expRes});
      checkOutput({tag, "_count"}, {28'd0, bus.shift_count}, expCnt);
      checkOutput({tag, "_zero"}, {31'd0, bus.zero}, {31'd0, expZero});
      checkOutput({tag, "_busy_in_done"}, {31'd0, bus.busy}, 32'd1);
      @(posedge clk);
      #1;
      checkOutput({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
      checkOutput({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
      checkOutput({tag, "_done"}, {31'd0, bus.done}, 32'd0);
      checkOutput({tag, "_result"}, {24'd0, bus.result}, 32'd0);
      checkOutput({tag, "_count"}, {28'd0, bus.shift_count}, 32'd0);
      checkOutput({tag, "_zero"}, {31'd0, bus.zero}, 32'd0);
   endtask

   initial begin
      int lat;
      total       = 0;
      bad         = 0;
      bus.start   = 1'b0;
      bus.operand = '0;
`ifdef SHIFT_NORM_RIGHT_EN
      bus.direction = 1'b0;
`endif
      rst_n = 1'b0;
      #1;
      checkResetState("reset");
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Already normalized: no shifts, done two edges after the accept.
      applyStimulus(8'h80, 1'b0, 1'b0, lat);
      checkResult("msb_set", lat, 2, 8'h80, 0, 1'b0);

      // Worst nonzero case: seven shifts.
      applyStimulus(8'h01, 1'b0, 1'b0, lat);
      checkResult("lsb_only", lat, 9, 8'h80, 7, 1'b0);

      // Zero operand skips SHIFT entirely.
      applyStimulus(8'h00, 1'b0, 1'b0, lat);
      checkResult("zero_op", lat, 1, 8'h00, 8, 1'b1);

      // Mid-range value: 0x35 has two leading zeros.
      applyStimulus(8'h35, 1'b0, 1'b0, lat);
      checkResult("mid", lat, 4, 8'hD4, 2, 1'b0);

`ifdef SHIFT_NORM_RIGHT_EN
      applyStimulus(8'h28, 1'b1, 1'b0, lat);
      checkResult("right", lat, 5, 8'h05, 3, 1'b0);
      applyStimulus(8'h80, 1'b1, 1'b0, lat);
      checkResult("right_msb", lat, 9, 8'h01, 7, 1'b0);
`endif

      // A start of 0x80 arriving mid-operation must not disturb the first request.
      applyStimulus(8'h01, 1'b0, 1'b1, lat);
      checkResult("busy_ignore", lat, 9, 8'h80, 7, 1'b0);

      // Reset after edge 3 of a 0x01 operation aborts it with no done pulse.
      @(negedge clk);
      bus.start   = 1'b1;
      bus.operand = 8'h01;
      @(posedge clk);
      #1;
      bus.start   = 1'b0;
      bus.operand = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checkResetState("abort");
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         checkOutput("abort_no_done", {31'd0, bus.done}, 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(8'h10, 1'b0, 1'b0, lat);
      checkResult("after_reset", lat, 5, 8'h80, 3, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
